// File: rtl/matrix_result_collector.sv
// Collects m x m result words from the upstream multiplier, then drains them in row-major order.
// Optional build macro COLLECTOR_CLEAR_EN zeroes the matrix, one word per cycle, after each start.
module matrix_result_collector #(
  parameter int m     = 4,
  parameter int m_len = $clog2(m)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mul_done,
  input  logic [31:0]      z_in,
  input  logic [m_len-1:0] z_i_in,
  input  logic [m_len-1:0] z_j_in,
  input  logic             z_stb,
  output logic             z_ack,
  output logic [31:0]      current_element,
  output logic             busy,
  output logic [31:0]      out_data,
  output logic [m_len-1:0] out_i,
  output logic [m_len-1:0] out_j,
  output logic             out_stb,
  input  logic             out_ack,
  output logic             out_last,
  output logic             drained
);

  localparam int IDX_W = 2 * m_len;
  localparam int DEPTH = m * m;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef COLLECTOR_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COLLECT, S_ACK, S_DRAIN, S_FIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ACK, S_DRAIN, S_FIN} state_t;
`endif

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             done_pending, done_pending_nxt;
  logic             z_ack_nxt;

  logic             mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem [DEPTH];

  function automatic logic [IDX_W-1:0] flat_addr(input logic [m_len-1:0] i,
                                                 input logic [m_len-1:0] j);
    return IDX_W'(i) * IDX_W'(m) + IDX_W'(j);
  endfunction

  assign current_element = mem[flat_addr(z_i_in, z_j_in)];
  assign busy            = (state != S_IDLE);
  assign out_stb         = (state == S_DRAIN);
  assign out_last        = out_stb && (idx == LAST_IDX);
  assign drained         = (state == S_FIN);
  assign out_data        = mem[idx];
  assign out_i           = m_len'(idx / IDX_W'(m));
  assign out_j           = m_len'(idx % IDX_W'(m));

  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    done_pending_nxt = done_pending;
    z_ack_nxt        = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = flat_addr(z_i_in, z_j_in);
    mem_wdata        = z_in;

    // mul_done can arrive while an element handshake is still open; remember it.
    if ((state == S_COLLECT || state == S_ACK) && mul_done) done_pending_nxt = 1'b1;

    case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt = '0;
`ifdef COLLECTOR_CLEAR_EN
          state_nxt = S_CLEAR;
`else
          state_nxt = S_COLLECT;
`endif
        end
      end
`ifdef COLLECTOR_CLEAR_EN
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = idx;
        mem_wdata = '0;
        if (idx == LAST_IDX) begin
          idx_nxt   = '0;
          state_nxt = S_COLLECT;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
`endif
      S_COLLECT: begin
        if (z_stb) begin
          mem_we    = 1'b1;
          z_ack_nxt = 1'b1;
          state_nxt = S_ACK;
        end else if (done_pending) begin
          done_pending_nxt = 1'b0;
          idx_nxt          = '0;
          state_nxt        = S_DRAIN;
        end
      end
      S_ACK: begin
        // Wait for the strobe to drop so a held strobe is captured only once.
        if (!z_stb) state_nxt = S_COLLECT;
      end
      S_DRAIN: begin
        if (out_ack) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = S_FIN;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers: async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      done_pending <= 1'b0;
      z_ack        <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      done_pending <= done_pending_nxt;
      z_ack        <= z_ack_nxt;
    end
  end

  // Result storage: no reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

endmodule

// File: tb/tb_matrix_result_collector.sv
// Self-checking bench for matrix_result_collector: table vectors, directed corner sequences,
// and randomized writes/drains against a plain-array reference of the result matrix.
module tb_matrix_result_collector;
  localparam int M  = 4;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, mul_done, z_stb, out_ack;
  logic [31:0]   z_in;
  logic [ML-1:0] z_i_in, z_j_in;
  logic          z_ack, busy, out_stb, out_last, drained;
  logic [31:0]   current_element, out_data;
  logic [ML-1:0] out_i, out_j;

  matrix_result_collector #(.m(M), .m_len(ML)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mul_done(mul_done),
    .z_in(z_in), .z_i_in(z_i_in), .z_j_in(z_j_in), .z_stb(z_stb),
    .z_ack(z_ack), .current_element(current_element), .busy(busy),
    .out_data(out_data), .out_i(out_i), .out_j(out_j), .out_stb(out_stb),
    .out_ack(out_ack), .out_last(out_last), .drained(drained)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [16];

  typedef struct {
    logic [1:0]  i, j;
    logic [31:0] z;
    logic [1:0]  ri, rj;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
`ifdef COLLECTOR_CLEAR_EN
    for (int k = 0; k < 16; k++) begin
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_zack", 32'(z_ack), 32'd0);
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = 32'd0;
      z_i_in = 2'(k / 4);
      z_j_in = 2'(k % 4);
      #1;
      chk("clr_zero", current_element, 32'd0);
    end
`endif
  endtask

  task automatic write_elem(input logic [1:0] i, input logic [1:0] j, input logic [31:0] z);
    int n;
    z_i_in = i;
    z_j_in = j;
    z_in   = z;
    z_stb  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!z_ack && n < 50);
    chk("zack_seen", 32'(z_ack), 32'd1);
    chk("ce_same_cycle", current_element, z);
    ref_mem[int'(i) * 4 + int'(j)] = z;
    z_stb = 1'b0;
    tick();
    chk("zack_pulse_end", 32'(z_ack), 32'd0);
  endtask

  task automatic drain_check(input int mode);
    logic [31:0] exp_q [$];
    int e, cyc, stall;
    logic a;
    for (int k = 0; k < 16; k++) exp_q.push_back(ref_mem[k]);
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    cyc = 0;
    while (!out_stb && cyc < 20) begin
      tick();
      cyc++;
    end
    e = 0; cyc = 0; stall = 0;
    while (e < 16 && cyc < 1000) begin
      chk("drn_stb", 32'(out_stb), 32'd1);
      chk("drn_data", out_data, exp_q[e]);
      chk("drn_i", 32'(out_i), 32'(e / 4));
      chk("drn_j", 32'(out_j), 32'(e % 4));
      chk("drn_last", 32'(out_last), 32'(e == 15));
      case (mode)
        0: a = 1'b1;
        1: begin
          if (e == 7 && stall < 5) begin
            a = 1'b0;
            stall++;
          end else begin
            a = 1'b1;
          end
        end
        default: begin
          a        = 1'($urandom_range(0, 1));
          start    = 1'($urandom_range(0, 1));
          mul_done = 1'($urandom_range(0, 1));
        end
      endcase
      out_ack = a;
      tick();
      if (a) e++;
      cyc++;
    end
    out_ack  = 1'b0;
    start    = 1'b0;
    mul_done = 1'b0;
    chk("drn_count", 32'(e), 32'd16);
    if (mode == 1) chk("drn_stall", 32'(stall), 32'd5);
    chk("drn_drained", 32'(drained), 32'd1);
    chk("drn_fin_busy", 32'(busy), 32'd1);
    tick();
    chk("drn_drained_end", 32'(drained), 32'd0);
    chk("drn_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int e, cyc, acks;
    rst_n = 1'b0; start = 1'b0; mul_done = 1'b0; z_stb = 1'b0; out_ack = 1'b0;
    z_in = '0; z_i_in = '0; z_j_in = '0;
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'd0;

    tbl[0] = '{2'd0, 2'd0, 32'h3F800000, 2'd0, 2'd0, 32'h3F800000};
    tbl[1] = '{2'd0, 2'd0, 32'h40400000, 2'd0, 2'd0, 32'h40400000};
    tbl[2] = '{2'd3, 2'd3, 32'hAAAA5555, 2'd3, 2'd3, 32'hAAAA5555};
    tbl[3] = '{2'd0, 2'd0, 32'h40C00000, 2'd3, 2'd3, 32'hAAAA5555};
    tbl[4] = '{2'd2, 2'd1, 32'h00000001, 2'd0, 2'd0, 32'h40C00000};
    tbl[5] = '{2'd0, 2'd0, 32'h41200000, 2'd0, 2'd0, 32'h41200000};
    tbl[6] = '{2'd1, 2'd0, 32'hFFFFFFFF, 2'd1, 2'd0, 32'hFFFFFFFF};
    tbl[7] = '{2'd0, 2'd1, 32'h80000000, 2'd2, 2'd1, 32'h00000001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zack", 32'(z_ack), 32'd0);
    chk("rst_out_stb", 32'(out_stb), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Fill the whole matrix, then table-driven overwrite/readback
    do_start();
    for (int k = 0; k < 16; k++)
      write_elem(2'(k / 4), 2'(k % 4), 32'h30000000 + 32'(k) * 32'h0101);
    for (int t = 0; t < 8; t++) begin
      write_elem(tbl[t].i, tbl[t].j, tbl[t].z);
      z_i_in = tbl[t].ri;
      z_j_in = tbl[t].rj;
      #1;
      chk("tbl_read", current_element, tbl[t].exp);
    end

    // Strobe held 3 cycles gives exactly one ack
    z_i_in = 2'd1; z_j_in = 2'd2; z_in = 32'h3F800000; z_stb = 1'b1;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_zack", 32'(z_ack), 32'(c == 0));
      if (z_ack) acks++;
    end
    z_stb = 1'b0;
    ref_mem[6] = 32'h3F800000;
    tick();
    chk("hold_ack_count", 32'(acks), 32'd1);
    chk("hold_mem", current_element, 32'h3F800000);

    // Full drain with out_ack high
    drain_check(0);

    // Drain with a 5-cycle stall at index 7
    do_start();
    write_elem(2'd1, 2'd3, 32'hDEADBEEF);
    write_elem(2'd2, 2'd2, 32'h12345678);
    drain_check(1);

    // Randomized writes and drain with random backpressure plus ignored start/mul_done
    do_start();
    for (int r = 0; r < 30; r++)
      write_elem(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
    drain_check(2);

    // A mul_done seen outside collection must not leak into the next collection
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    do_start();
    for (int c = 0; c < 4; c++) begin
      chk("no_leak_stb", 32'(out_stb), 32'd0);
      tick();
    end

    // Reset in the middle of a drain
    write_elem(2'd3, 2'd0, 32'h0BADF00D);
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    cyc = 0;
    while (!out_stb && cyc < 20) begin
      tick();
      cyc++;
    end
    e = 0;
    out_ack = 1'b1;
    while (e < 9 && cyc < 100) begin
      tick();
      e++;
      cyc++;
    end
    out_ack = 1'b0;
    chk("rd_pos_i", 32'(out_i), 32'd2);
    chk("rd_pos_j", 32'(out_j), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rd_out_stb", 32'(out_stb), 32'd0);
    chk("rd_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    z_i_in = 2'd2; z_j_in = 2'd2; z_in = 32'h55555555; z_stb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rd_no_zack", 32'(z_ack), 32'd0);
      chk("rd_idle", 32'(busy), 32'd0);
    end
    z_stb = 1'b0;
    tick();
    do_start();
    write_elem(2'd2, 2'd2, 32'h55555555);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/matrix_result_collector.md
MATRIX_RESULT_COLLECTOR -- requirements
Module: matrix_result_collector

Interface
REQ-001 Parameter m, default 4: matrix dimension; the result matrix holds m*m words of 32 bits.
REQ-002 Parameter m_len, default $clog2(m): row and column index width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins collection of a new result matrix.
REQ-007 mul_done  input  1  one-cycle pulse from the upstream multiplier: all elements produced.
REQ-008 z_in  input  32  element value (IEEE-754 single) from the upstream multiplier.
REQ-009 z_i_in, z_j_in  input  m_len each  row and column of z_in.
REQ-010 z_stb  input  1  z_in, z_i_in and z_j_in are valid; held high until z_ack is seen.
REQ-011 z_ack  output  1  registered one-cycle acknowledge of a captured element.
REQ-012 current_element  output  32  combinational mem[z_i_in][z_j_in], fed back to the multiplier.
REQ-013 busy  output  1  high in every state except S_IDLE.
REQ-014 out_data, out_i, out_j  output  32, m_len, m_len  drained element and its position.
REQ-015 out_stb  output  1  drain word valid.  out_ack  input  1  downstream accepts the drain word.
REQ-016 out_last  output  1  high together with out_stb on element (m-1,m-1).
REQ-017 drained  output  1  one-cycle pulse after the final drain word is accepted.

Function
REQ-018 The FSM SHALL have states S_IDLE, S_CLEAR, S_COLLECT, S_ACK, S_DRAIN and S_FIN.
REQ-019 S_IDLE: start SHALL move to S_CLEAR when the clear feature is compiled in, else to S_COLLECT; all other inputs are ignored.
REQ-020 S_COLLECT with z_stb=1: mem[z_i_in][z_j_in] <= z_in, z_ack <= 1 on the next edge, move to S_ACK.
REQ-021 S_ACK: z_ack <= 0; return to S_COLLECT only once z_stb=0, so one strobe is never captured twice.
REQ-022 Repeated writes to the same (i,j) SHALL overwrite: partial sums accumulate and the last write wins.
REQ-023 A mul_done pulse in S_COLLECT or S_ACK SHALL set done_pending; a pulse in any other state is ignored.
REQ-024 S_COLLECT with done_pending=1 and z_stb=0: clear done_pending, set idx=0, move to S_DRAIN; z_stb=1 takes priority.
REQ-025 S_DRAIN: out_stb=1, out_data=mem[idx], out_i=idx/m, out_j=idx%m (row-major order); idx has width 2*m_len.
REQ-026 S_DRAIN with out_ack=1: idx <= idx+1; when idx=m*m-1, move to S_FIN instead; the output words SHALL hold stable while out_ack=0.
REQ-027 S_FIN: drained=1 for one cycle, then S_IDLE.
REQ-028 start outside S_IDLE SHALL be ignored.
REQ-029 Capture latency SHALL be 1 cycle from z_stb sampled to z_ack high; the new value is visible on current_element in that same cycle.

Reset
REQ-030 When rst_n=0, asynchronously: state=S_IDLE, z_ack=0, out_stb=0, out_last=0, drained=0, done_pending=0, idx=0.
REQ-031 Memory contents SHALL NOT be reset; reset mid-collect or mid-drain abandons the operation without resuming.

Configuration
REQ-032 Macro COLLECTOR_CLEAR_EN defined: S_CLEAR writes 0 to one entry per cycle at idx 0..m*m-1 (m*m cycles), then enters S_COLLECT; z_ack stays 0 during S_CLEAR.
REQ-033 Macro COLLECTOR_CLEAR_EN undefined: S_CLEAR is absent and memory retains its previous contents across start.

Verification
REQ-034 With CLEAR_EN: start, then wait 16 cycles -> busy=1, z_ack=0 throughout; current_element=0 at all 16 positions.
REQ-035 In S_COLLECT: z_stb=1, z_in=32'h3F800000, (i,j)=(1,2), held 3 cycles -> exactly one z_ack pulse, 1 cycle after z_stb; mem[1][2]=32'h3F800000.
REQ-036 Four writes to (0,0): 1.0, 3.0, 6.0, 10.0 -> current_element=32'h41200000 (10.0).
REQ-037 Fill all 16 entries, pulse mul_done, out_ack tied to 1 -> 16 words in row-major order; out_last only on (3,3); drained pulses 1 cycle later.
REQ-038 During drain, out_ack=0 for 5 cycles at idx=7 -> out_data and out_i/out_j held at (1,3); drain then resumes in order.
REQ-039 rst_n=0 at idx=9 of the drain -> out_stb=0, busy=0 immediately; after release, start is required before any z_ack.
